// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared encodings and default widths
package y86_pkg;

    localparam int Y86_DATA_W = 64;
    localparam int Y86_ADDR_W = 4;
    localparam int Y86_NREGS  = 15;
    localparam int Y86_PEND_W = 2;

    typedef enum logic [3:0] {
        RRAX  = 4'h0,
        RRCX  = 4'h1,
        RRDX  = 4'h2,
        RRBX  = 4'h3,
        RRSP  = 4'h4,
        RRBP  = 4'h5,
        RRSI  = 4'h6,
        RRDI  = 4'h7,
        R8    = 4'h8,
        R9    = 4'h9,
        R10   = 4'hA,
        R11   = 4'hB,
        R12   = 4'hC,
        R13   = 4'hD,
        R14   = 4'hE,
        RNONE = 4'hF
    } reg_id_t;

    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } icode_t;

endpackage

// File: rtl/y86_reg_scoreboard.sv
// rtl/y86_reg_scoreboard.sv - per-register pending-write counters; REGFILE_BYPASS_EN masks busy on retiring write
module y86_reg_scoreboard
    import y86_pkg::*;
#(
    parameter int NREGS  = Y86_NREGS,
    parameter int ADDR_W = Y86_ADDR_W,
    parameter int PEND_W = Y86_PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_E,
    input  logic [ADDR_W-1:0] alloc_M,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic              busyA,
    output logic              busyB,
    output logic              pend_ovf
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [PEND_W-1:0] pend_q [NREGS];
    logic [PEND_W-1:0] pend_d [NREGS];
    logic              ovf_q;
    logic              ovf_d;

    function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
        return (idx != ADDR_W'(RNONE)) && (int'(idx) < NREGS);
    endfunction

    // Per-register increment on allocation, decrement on writeback; both cancel
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NREGS; i++) begin
            logic inc;
            logic dec;
            pend_d[i] = pend_q[i];
            inc = alloc_en && ((idx_ok(alloc_E) && alloc_E == ADDR_W'(i)) ||
                               (idx_ok(alloc_M) && alloc_M == ADDR_W'(i)));
            dec = wr_en && ((idx_ok(dstE) && dstE == ADDR_W'(i)) ||
                            (idx_ok(dstM) && dstM == ADDR_W'(i)));
            if (inc && !dec) begin
                if (pend_q[i] == PEND_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + 1'b1;
                end
            end else if (dec && !inc) begin
                if (pend_q[i] != '0) begin
                    pend_d[i] = pend_q[i] - 1'b1;
                end
            end
        end
    end

    // Counter and sticky overflow state, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                pend_q[i] <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                pend_q[i] <= pend_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    // Busy lookups from registered counters
    always_comb begin
        busyA = idx_ok(srcA) && (pend_q[srcA] != '0);
        busyB = idx_ok(srcB) && (pend_q[srcB] != '0);
`ifdef REGFILE_BYPASS_EN
        if (busyA && wr_en && pend_q[srcA] == PEND_W'(1) &&
            ((idx_ok(dstE) && dstE == srcA) || (idx_ok(dstM) && dstM == srcA))) begin
            busyA = 1'b0;
        end
        if (busyB && wr_en && pend_q[srcB] == PEND_W'(1) &&
            ((idx_ok(dstE) && dstE == srcB) || (idx_ok(dstM) && dstM == srcB))) begin
            busyB = 1'b0;
        end
`endif
    end

    assign pend_ovf = ovf_q;

endmodule

// File: rtl/y86_regfile_mp.sv
// rtl/y86_regfile_mp.sv - two-read/two-write Y86-64 register file; REGFILE_BYPASS_EN forwards same-cycle writes
module y86_regfile_mp
    import y86_pkg::*;
#(
    parameter int DATA_W = Y86_DATA_W,
    parameter int NREGS  = Y86_NREGS,
    parameter int ADDR_W = Y86_ADDR_W,
    parameter int PEND_W = Y86_PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              busyA,
    output logic              busyB,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_E,
    input  logic [ADDR_W-1:0] alloc_M,
    output logic              pend_ovf
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
        return (idx != ADDR_W'(RNONE)) && (int'(idx) < NREGS);
    endfunction

    // Write decode: M is applied after E so it wins on a shared index (popq %rsp)
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && idx_ok(dstE) && dstE == ADDR_W'(i)) begin
                regs_d[i] = valE;
            end
            if (wr_en && idx_ok(dstM) && dstM == ADDR_W'(i)) begin
                regs_d[i] = valM;
            end
        end
    end

    // Register storage, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] src);
        logic [DATA_W-1:0] val;
        val = '0;
        if (idx_ok(src)) begin
            val = regs_q[src];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && idx_ok(dstM) && dstM == src) begin
                val = valM;
            end else if (wr_en && idx_ok(dstE) && dstE == src) begin
                val = valE;
            end
`endif
        end
        return val;
    endfunction

    // Combinational read ports, forced to zero while reset is held
    always_comb begin
        valA = rst ? '0 : read_port(srcA);
        valB = rst ? '0 : read_port(srcB);
    end

    y86_reg_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W),
        .PEND_W (PEND_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .alloc_en (alloc_en),
        .alloc_E  (alloc_E),
        .alloc_M  (alloc_M),
        .wr_en    (wr_en),
        .dstE     (dstE),
        .dstM     (dstM),
        .srcA     (srcA),
        .srcB     (srcB),
        .busyA    (busyA),
        .busyB    (busyB),
        .pend_ovf (pend_ovf)
    );

endmodule
